dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Sequences and shares the single-port, word-indexed, big-endian data memory (dmem) between two requesters.
  - Port 0: CPU load/store unit.
  - Port 1: DMA/program loader.
- Adds byte and halfword access on top of the word-only memory.
  - Sub-word loads use lane extraction with sign or zero extension.
  - Sub-word stores use a read-modify-write sequence.
- Sits between the requesters and dmem. Drives dmem's r_w, mem_addr and mem_data. Samples dmem's combinational mem_out.

Parameters:
- AddrSize, 8: dmem word-index width; addressable range is 0 to 4*(2^AddrSize)-1 bytes.

Ports:
- clk  in  1  clock; all state updates on the rising edge
- reset_n  in  1  asynchronous active-low reset
- req  in  2  request per port; bit i belongs to port i
- we  in  2  1 = store, 0 = load, per port
- size  in  4  per-port size in 2-bit fields [2i+1:2i]: 00 byte, 01 half, 10 word, 11 illegal
- uns  in  2  per-port load extension: 1 = zero-extend, 0 = sign-extend
- addr  in  64  per-port byte address, field [32i+31:32i]
- wdata  in  64  per-port store data, field [32i+31:32i]; sub-word data taken from the low bits
- done  out  2  one-cycle completion pulse to the granted port
- err  out  2  valid with done; 1 = access rejected
- rdata  out  32  load result, valid in the done cycle
- mem_r_w  out  1  dmem write enable
- mem_addr  out  32  dmem word index {zeros, addr[AddrSize+1:2]}
- mem_data  out  32  dmem write data
- mem_out  in  32  dmem combinational read data

Behaviour:
- Reset (asynchronous, effective immediately, including mid-operation):
  - State goes to IDLE.
  - done, err, rdata, mem_r_w, mem_addr and mem_data all go to 0.
  - last_gnt goes to 1, so port 0 wins the first contention.
  - A sub-word write in progress is abandoned. No partial write is allowed: mem_r_w is decoded from state, so it drops at once.
- States: IDLE, ACCESS, RMW_WR, DONE.
- IDLE:
  - If any req bit is set, grant one port:
    - Single requester: that port.
    - Both requesting: the port != last_gnt (round-robin).
  - On grant, latch the port's we, size, uns, addr and wdata; update last_gnt; go to ACCESS.
  - Legality is checked at grant time. The access is illegal if any of these hold:
    - size = 11.
    - Half with addr[0] = 1.
    - Word with addr[1:0] != 0.
    - addr[31:AddrSize+2] != 0.
  - Illegal access: skip the memory cycles and go straight to DONE with err = 1 and rdata = 0. mem_r_w is never asserted.
- ACCESS: mem_addr holds the latched word index.
  - Load: capture mem_out, extract the lane, extend, register into rdata; go to DONE.
  - Word store: mem_r_w = 1 and mem_data = wdata for this cycle; go to DONE.
  - Sub-word store: capture mem_out into the merge register; go to RMW_WR.
- RMW_WR:
  - mem_r_w = 1.
  - mem_data = captured word with the target lane replaced.
  - Go to DONE.
- Lane mapping (big-endian):
  - Byte at addr[1:0] = 0/1/2/3 maps to bits [31:24] / [23:16] / [15:8] / [7:0].
  - Half at addr[1] = 0/1 maps to bits [31:16] / [15:0].
- DONE:
  - done[granted port] = 1 for exactly one cycle, with err and rdata valid.
  - rdata is held until the next done. err is 0 outside the done cycle.
  - Go to IDLE.
- Requester protocol:
  - Hold req and the request fields until done.
  - Deassert req in the done cycle, or keep it asserted to issue a new request.
  - Fields sampled only at grant; changes after grant are ignored.
- Latency from grant cycle (the IDLE cycle with req seen) to done:
  - Load or word store: 2 cycles.
  - Sub-word store: 3 cycles.
  - Error: 1 cycle.
- Throughput: no arbitration in DONE, so a minimum of 3 cycles per access.
- A losing requester waits. Round-robin guarantees it is served by the next grant.
- mem_r_w is asserted only in ACCESS (word store) or RMW_WR. It is never asserted for loads or errors.

Test Plan:
- Word round trip:
  - Port 0 stores 0xDEADBEEF at addr 0x10.
  - mem_r_w is high one cycle with mem_addr = 4; done[0] arrives 2 cycles after grant.
  - Port 0 then loads addr 0x10: rdata = 0xDEADBEEF, err = 0.
- Byte store and load:
  - Preload word 4 with 0x11223344; port 1 stores byte 0xAA at addr 0x11.
  - Memory becomes 0x11AA3344; done[1] arrives 3 cycles after grant.
  - lb at 0x11 returns 0xFFFFFFAA; lbu returns 0x000000AA; lhu at 0x12 returns 0x00003344.
- Arbitration:
  - Both ports request continuously from reset.
  - Grants alternate 0, 1, 0, 1; each done arrives on the correct bit; no port is starved.
- Errors:
  - Word at 0x13, half at 0x01, size = 11, and addr = 0x400 (AddrSize = 8) each give err = 1 and rdata = 0.
  - mem_r_w is never asserted; done arrives 1 cycle after grant.
- Reset mid-RMW:
  - Assert reset_n = 0 during ACCESS of a byte store to 0x20.
  - mem_r_w stays 0 and the word at index 8 is unchanged.
  - All outputs are 0; after release, port 0 wins first contention.
- Request held through done:
  - Port 0 keeps req asserted through done.
  - A second grant is issued in the following IDLE cycle; back-to-back period is 3 cycles.

Source files
------------

// File: rtl/dmem_arbiter.sv
// Two-port arbiter in front of a word-only, big-endian dmem. It adds byte and
// halfword access, using lane extraction for loads and read-modify-write for stores.
module dmem_arbiter #(
  parameter int unsigned AddrSize = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  req,
  input  logic [1:0]  we,
  input  logic [3:0]  size,
  input  logic [1:0]  uns,
  input  logic [63:0] addr,
  input  logic [63:0] wdata,
  output logic [1:0]  done,
  output logic [1:0]  err,
  output logic [31:0] rdata,
  output logic        mem_r_w,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_data,
  input  logic [31:0] mem_out
);

  typedef enum logic [1:0] {IDLE, ACCESS, RMW_WR, DONE} state_t;

  state_t              state, state_nx;
  logic                gnt_q, last_gnt;
  logic                we_q, uns_q, err_q;
  logic [1:0]          size_q;
  logic [AddrSize+1:0] addr_q;
  logic [31:0]         wdata_q, merge_q;

  logic                gnt_sel, g_illegal;
  logic [1:0]          g_size;
  logic [31:0]         g_addr;
  logic [31:0]         load_val, merged;
  logic [7:0]          lane_b;
  logic [15:0]         lane_h;

  // On contention, pick the port that was not granted last.
  always_comb begin
    gnt_sel = (req == 2'b11) ? ~last_gnt : req[1];
    g_size  = size[{gnt_sel, 1'b0} +: 2];
    g_addr  = addr[{gnt_sel, 5'b0} +: 32];
    g_illegal = (g_size == 2'b11)
             || (g_size == 2'b01 && g_addr[0])
             || (g_size == 2'b10 && g_addr[1:0] != 2'b00)
             || ((g_addr >> (AddrSize + 2)) != '0);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (|req) state_nx = g_illegal ? DONE : ACCESS;
      ACCESS:  state_nx = (we_q && size_q != 2'b10) ? RMW_WR : DONE;
      RMW_WR:  state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    lane_b = 8'h00;
    unique case (addr_q[1:0])
      2'd0: lane_b = mem_out[31:24];
      2'd1: lane_b = mem_out[23:16];
      2'd2: lane_b = mem_out[15:8];
      2'd3: lane_b = mem_out[7:0];
      default: lane_b = 8'h00;
    endcase
    lane_h = addr_q[1] ? mem_out[15:0] : mem_out[31:16];
    unique case (size_q)
      2'b00:   load_val = uns_q ? {24'h0, lane_b} : {{24{lane_b[7]}}, lane_b};
      2'b01:   load_val = uns_q ? {16'h0, lane_h} : {{16{lane_h[15]}}, lane_h};
      default: load_val = mem_out;
    endcase
  end

  always_comb begin
    merged = merge_q;
    if (size_q == 2'b00) begin
      unique case (addr_q[1:0])
        2'd0: merged[31:24] = wdata_q[7:0];
        2'd1: merged[23:16] = wdata_q[7:0];
        2'd2: merged[15:8]  = wdata_q[7:0];
        2'd3: merged[7:0]   = wdata_q[7:0];
        default: merged = merge_q;
      endcase
    end else if (addr_q[1]) begin
      merged[15:0] = wdata_q[15:0];
    end else begin
      merged[31:16] = wdata_q[15:0];
    end
  end

  // Write strobe and write data come straight from state, so a reset mid-RMW drops them immediately.
  always_comb begin
    done     = '0;
    err      = '0;
    mem_r_w  = 1'b0;
    mem_data = '0;
    mem_addr = '0;
    mem_addr[AddrSize-1:0] = addr_q[AddrSize+1:2];
    unique case (state)
      ACCESS: if (we_q && size_q == 2'b10) begin
        mem_r_w  = 1'b1;
        mem_data = wdata_q;
      end
      RMW_WR: begin
        mem_r_w  = 1'b1;
        mem_data = merged;
      end
      DONE: begin
        done = {gnt_q, ~gnt_q};
        err  = err_q ? {gnt_q, ~gnt_q} : 2'b00;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      gnt_q    <= 1'b0;
      last_gnt <= 1'b1;
      we_q     <= 1'b0;
      uns_q    <= 1'b0;
      err_q    <= 1'b0;
      size_q   <= '0;
      addr_q   <= '0;
      wdata_q  <= '0;
      merge_q  <= '0;
      rdata    <= '0;
    end else begin
      if (state == IDLE && |req) begin
        gnt_q    <= gnt_sel;
        last_gnt <= gnt_sel;
        we_q     <= we[gnt_sel];
        uns_q    <= uns[gnt_sel];
        size_q   <= g_size;
        addr_q   <= g_addr[AddrSize+1:0];
        wdata_q  <= wdata[{gnt_sel, 5'b0} +: 32];
        err_q    <= g_illegal;
        if (g_illegal) rdata <= '0;
      end
      if (state == ACCESS) begin
        if (!we_q)                    rdata   <= load_val;
        else if (size_q != 2'b10)     merge_q <= mem_out;
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// Directed bench for dmem_arbiter against a behavioural 256-word dmem.
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  req, we, uns;
  logic [3:0]  size;
  logic [63:0] addr, wdata;
  logic [1:0]  done, err;
  logic [31:0] rdata, mem_addr, mem_data, mem_out;
  logic        mem_r_w;

  logic [31:0] mem [0:255];
  int          wr_cnt = 0;
  logic [31:0] last_wa = '0;
  int          total = 0;
  int          bad = 0;

  dmem_arbiter #(.AddrSize(8)) dut (
    .clk(clk), .reset_n(reset_n), .req(req), .we(we), .size(size), .uns(uns),
    .addr(addr), .wdata(wdata), .done(done), .err(err), .rdata(rdata),
    .mem_r_w(mem_r_w), .mem_addr(mem_addr), .mem_data(mem_data), .mem_out(mem_out)
  );

  always #5 clk = ~clk;

  assign mem_out = mem[mem_addr[7:0]];

  always @(posedge clk) begin
    if (mem_r_w) begin
      mem[mem_addr[7:0]] <= mem_data;
      wr_cnt  <= wr_cnt + 1;
      last_wa <= mem_addr;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic wait_done(input int limit, output int n, output logic [1:0] dn);
    n  = 0;
    dn = '0;
    while (n < limit) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (|done) begin
        dn = done;
        return;
      end
    end
    check("done_timeout", {30'b0, done}, 32'h1);
  endtask

  task automatic set_port(input int p, input logic w, input logic [1:0] sz, input logic u,
                          input logic [31:0] a, input logic [31:0] d);
    we[p]            = w;
    size[2*p +: 2]   = sz;
    uns[p]           = u;
    addr[32*p +: 32] = a;
    wdata[32*p +: 32] = d;
    req[p]           = 1'b1;
  endtask

  task automatic do_req(input int p, input logic w, input logic [1:0] sz, input logic u,
                        input logic [31:0] a, input logic [31:0] d,
                        output int lat, output logic [1:0] dn, output logic [1:0] e,
                        output logic [31:0] rd);
    set_port(p, w, sz, u, a, d);
    wait_done(10, lat, dn);
    e  = err;
    rd = rdata;
    req[p] = 1'b0;
    @(negedge clk);
  endtask

  initial begin
    int          lat, wc;
    logic [1:0]  dn, e;
    logic [31:0] rd;

    reset_n = 1'b0;
    req = '0; we = '0; uns = '0; size = '0; addr = '0; wdata = '0;
    for (int i = 0; i < 256; i++) mem[i] = 32'h0;
    #1;
    check("rst_done", {30'b0, done}, 32'h0);
    check("rst_err", {30'b0, err}, 32'h0);
    check("rst_rdata", rdata, 32'h0);
    check("rst_mem_r_w", {31'b0, mem_r_w}, 32'h0);
    check("rst_mem_addr", mem_addr, 32'h0);
    check("rst_mem_data", mem_data, 32'h0);
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // Word round trip
    wc = wr_cnt;
    do_req(0, 1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, lat, dn, e, rd);
    check("sw_lat", 32'(lat), 32'd2);
    check("sw_done", {30'b0, dn}, 32'h1);
    check("sw_err", {30'b0, e}, 32'h0);
    check("sw_wr_cnt", 32'(wr_cnt - wc), 32'd1);
    check("sw_wr_addr", last_wa, 32'd4);
    check("sw_mem", mem[4], 32'hDEADBEEF);
    do_req(0, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0, lat, dn, e, rd);
    check("lw_lat", 32'(lat), 32'd2);
    check("lw_rdata", rd, 32'hDEADBEEF);
    check("lw_err", {30'b0, e}, 32'h0);

    // Byte store via RMW, then sub-word loads
    mem[4] = 32'h11223344;
    wc = wr_cnt;
    do_req(1, 1'b1, 2'b00, 1'b0, 32'h11, 32'h123456AA, lat, dn, e, rd);
    check("sb_lat", 32'(lat), 32'd3);
    check("sb_done", {30'b0, dn}, 32'h2);
    check("sb_wr_cnt", 32'(wr_cnt - wc), 32'd1);
    check("sb_mem", mem[4], 32'h11AA3344);
    do_req(1, 1'b0, 2'b00, 1'b0, 32'h11, 32'h0, lat, dn, e, rd);
    check("lb_rdata", rd, 32'hFFFFFFAA);
    do_req(0, 1'b0, 2'b00, 1'b1, 32'h11, 32'h0, lat, dn, e, rd);
    check("lbu_rdata", rd, 32'h000000AA);
    do_req(0, 1'b0, 2'b01, 1'b1, 32'h12, 32'h0, lat, dn, e, rd);
    check("lhu_rdata", rd, 32'h00003344);
    do_req(0, 1'b0, 2'b01, 1'b0, 32'h10, 32'h0, lat, dn, e, rd);
    check("lh_rdata", rd, 32'h000011AA);
    do_req(1, 1'b1, 2'b01, 1'b0, 32'h12, 32'h0000BEEF, lat, dn, e, rd);
    check("sh_lat", 32'(lat), 32'd3);
    check("sh_mem", mem[4], 32'h11AABEEF);
    do_req(0, 1'b0, 2'b00, 1'b0, 32'h13, 32'h0, lat, dn, e, rd);
    check("lb3_rdata", rd, 32'hFFFFFFEF);

    // Illegal accesses
    wc = wr_cnt;
    do_req(0, 1'b1, 2'b10, 1'b0, 32'h13, 32'h1, lat, dn, e, rd);
    check("e_word_lat", 32'(lat), 32'd1);
    check("e_word_err", {30'b0, e}, 32'h1);
    check("e_word_rdata", rd, 32'h0);
    do_req(1, 1'b1, 2'b01, 1'b0, 32'h01, 32'h1, lat, dn, e, rd);
    check("e_half_lat", 32'(lat), 32'd1);
    check("e_half_err", {30'b0, e}, 32'h2);
    do_req(0, 1'b0, 2'b11, 1'b0, 32'h00, 32'h0, lat, dn, e, rd);
    check("e_size_err", {30'b0, e}, 32'h1);
    check("e_size_rdata", rd, 32'h0);
    do_req(1, 1'b1, 2'b10, 1'b0, 32'h400, 32'h1, lat, dn, e, rd);
    check("e_range_lat", 32'(lat), 32'd1);
    check("e_range_err", {30'b0, e}, 32'h2);
    check("e_no_write", 32'(wr_cnt - wc), 32'd0);
    check("e_err_drops", {30'b0, err}, 32'h0);

    // Round-robin with both ports requesting continuously
    mem[8] = 32'h55667788;
    set_port(0, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    set_port(1, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0);
    for (int k = 0; k < 4; k++) begin
      wait_done(10, lat, dn);
      check("rr_done", {30'b0, dn}, (k % 2 == 0) ? 32'h1 : 32'h2);
      check("rr_rdata", rdata, (k % 2 == 0) ? 32'h11AABEEF : 32'h55667788);
      check("rr_period", 32'(lat), (k == 0) ? 32'd2 : 32'd3);
    end
    req = '0;
    @(negedge clk);

    // Reset during ACCESS of a byte store
    wc = wr_cnt;
    set_port(0, 1'b1, 2'b00, 1'b0, 32'h20, 32'h99);
    @(posedge clk);
    @(negedge clk);
    check("mr_access_addr", mem_addr, 32'd8);
    reset_n = 1'b0;
    req = '0;
    #1;
    check("mr_mem_r_w", {31'b0, mem_r_w}, 32'h0);
    check("mr_done", {30'b0, done}, 32'h0);
    check("mr_rdata", rdata, 32'h0);
    check("mr_mem_addr", mem_addr, 32'h0);
    check("mr_mem_data", mem_data, 32'h0);
    @(negedge clk);
    @(negedge clk);
    check("mr_mem_kept", mem[8], 32'h55667788);
    check("mr_no_write", 32'(wr_cnt - wc), 32'd0);
    reset_n = 1'b1;
    @(negedge clk);
    set_port(0, 1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
    set_port(1, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0);
    wait_done(10, lat, dn);
    check("mr_first_gnt", {30'b0, dn}, 32'h1);
    wait_done(10, lat, dn);
    check("mr_second_gnt", {30'b0, dn}, 32'h2);
    req = '0;
    @(negedge clk);

    // Request held through done
    set_port(0, 1'b0, 2'b10, 1'b0, 32'h20, 32'h0);
    wait_done(10, lat, dn);
    check("hold_first_lat", 32'(lat), 32'd2);
    check("hold_first_rdata", rdata, 32'h55667788);
    addr[31:0] = 32'h10;
    wait_done(10, lat, dn);
    check("hold_period", 32'(lat), 32'd3);
    check("hold_done", {30'b0, dn}, 32'h1);
    check("hold_rdata", rdata, 32'h11AABEEF);
    req = '0;
    @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
